// File: rtl/mfa_pkg.sv
// Shared types and default constants for the symbol scheduler and its FIFO.
package mfa_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      DRAIN     = 3'd2,
      WAIT_CORE = 3'd3,
      FINISH    = 3'd4
   } state_e;

   typedef logic [1:0] symbol_t;

   localparam int DEF_FIFO_DEPTH   = 8;
   localparam int DEF_ISSUE_GAP    = 2;
   localparam int DEF_DRAIN_CYCLES = 64;

endpackage

// File: rtl/sym_fifo.sv
// Symbol buffer between the upstream stream and the issue logic.
// Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
module sym_fifo
   import mfa_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [1:0] wdata,
   output logic [1:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   symbol_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push_s, do_pop_s;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == {(AW+1){1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign rdata     = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care once the pointers are cleared.
   always_ff @(posedge CLK) begin
      if (do_push_s && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/symbol_scheduler.sv
// Buffers upstream symbols and issues them to the matching core at a fixed
// pace, then drains with BC_mode low and waits for the core to report done.
module symbol_scheduler
   import mfa_pkg::*;
#(
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int ISSUE_GAP    = DEF_ISSUE_GAP,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [15:0] seq_len,
   input  logic [1:0]  in_symbol,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [1:0]  core_symbol,
   output logic        core_BC_mode,
   input  logic        core_done,
   output logic        busy,
   output logic        done,
   output logic [15:0] symbols_issued
);

   localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ISSUE_GAP - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

   state_e           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      issued_q, issued_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   symbol_t          sym_q, sym_d;
   logic             bc_q, bc_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             live_q;
   logic             push_s, pop_s, flush_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [1:0]       fifo_rdata_s;

   // live_q keeps in_ready low until the first edge after reset release.
   assign in_ready = live_q & ~fifo_full_s & ((state_q == IDLE) | (state_q == RUN));
   assign push_s   = in_valid & in_ready;
   assign pop_s    = (state_q == RUN) && (gap_q == {GAP_W{1'b0}}) &&
                     (issued_q < len_q) && !fifo_empty_s;
   assign flush_s  = (state_q == FINISH);

   assign core_symbol    = sym_q;
   assign core_BC_mode   = bc_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign symbols_issued = issued_q;

   sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (in_symbol),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Next-state and sequencing counters; an empty FIFO freezes the gap counter at zero.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      issued_d = issued_q;
      gap_d    = gap_q;
      drain_d  = drain_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d    = seq_len;
               issued_d = 16'd0;
               gap_d    = {GAP_W{1'b0}};
               if (seq_len == 16'd0) begin
                  state_d = DRAIN;
                  drain_d = DRN_LAST;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (gap_q != {GAP_W{1'b0}}) begin
               gap_d = gap_q - 1'b1;
            end else if (issued_q >= len_q) begin
               state_d = DRAIN;
               drain_d = DRN_LAST;
            end else if (pop_s) begin
               gap_d    = GAP_LAST;
               issued_d = (issued_q < len_q) ? issued_q + 16'd1 : len_q;
            end else begin
               gap_d = gap_q;
            end
         end
         DRAIN: begin
            if (drain_q == {DRN_W{1'b0}}) begin
               state_d = WAIT_CORE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         WAIT_CORE: begin
            if (core_done) begin
               state_d = FINISH;
            end else begin
               state_d = WAIT_CORE;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values, decoded from the upcoming state so outputs stay registered.
   always_comb begin
      bc_d   = (state_d == RUN);
      done_d = (state_d == FINISH);
      busy_d = (state_d != IDLE);
      if (pop_s) begin
         sym_d = fifo_rdata_s;
      end else if (state_d == DRAIN) begin
         sym_d = 2'b00;
      end else begin
         sym_d = sym_q;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         len_q    <= 16'd0;
         issued_q <= 16'd0;
         gap_q    <= {GAP_W{1'b0}};
         drain_q  <= {DRN_W{1'b0}};
         sym_q    <= 2'b00;
         bc_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         gap_q    <= gap_d;
         drain_q  <= drain_d;
         sym_q    <= sym_d;
         bc_q     <= bc_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         live_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_symbol_scheduler.sv
// Directed bench for symbol_scheduler: a queue-based reference model checked
// every cycle, plus hand-computed timing and ordering expectations per scenario.
module tb_symbol_scheduler;

   localparam int DEPTH = 8;
   localparam int GAP   = 2;
   localparam int DRN   = 64;

   logic        CLK       = 1'b0;
   logic        RST       = 1'b1;
   logic        start     = 1'b0;
   logic [15:0] seq_len   = 16'd0;
   logic [1:0]  in_symbol = 2'b00;
   logic        in_valid  = 1'b0;
   logic        core_done = 1'b0;
   logic        in_ready;
   logic [1:0]  core_symbol;
   logic        core_BC_mode;
   logic        busy;
   logic        done;
   logic [15:0] symbols_issued;

   always #5 CLK = ~CLK;

   symbol_scheduler #(.FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP), .DRAIN_CYCLES(DRN)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .start          (start),
      .seq_len        (seq_len),
      .in_symbol      (in_symbol),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .core_symbol    (core_symbol),
      .core_BC_mode   (core_BC_mode),
      .core_done      (core_done),
      .busy           (busy),
      .done           (done),
      .symbols_issued (symbols_issued)
   );

   int total = 0;
   int bad   = 0;

   // reference model: mode 0 idle, 1 issuing, 2 draining, 3 awaiting core, 4 finishing
   int         m_mode   = 0;
   logic [1:0] m_q[$];
   logic [1:0] m_cur    = 2'b00;
   int         m_issued = 0;
   int         m_len    = 0;
   int         m_left   = 0;
   int         m_drain  = 0;
   bit         m_live   = 1'b0;
   bit         acc;

   int         cyc         = 0;
   logic [15:0] prev_iss   = 16'd0;
   logic       prev_bc     = 1'b0;
   int         bc_fall_cyc = 0;
   int         bc_high     = 0;
   int         done_cnt    = 0;
   int         done_cyc    = 0;
   logic [1:0] issue_log[$];
   int         issue_cyc[$];
   logic [1:0] exp_syms[$];

   function automatic bit e_ready();
      return m_live && (m_mode <= 1) && (m_q.size() < DEPTH);
   endfunction

   task automatic model_step();
      acc = in_valid && e_ready();
      case (m_mode)
         0: if (start) begin
               m_len = int'(seq_len);
               m_issued = 0;
               m_left = 0;
               if (m_len == 0) begin m_mode = 2; m_drain = DRN; m_cur = 2'b00; end
               else m_mode = 1;
            end
         1: if (m_left > 0) m_left--;
            else if (m_issued == m_len) begin m_mode = 2; m_drain = DRN; m_cur = 2'b00; end
            else if (m_q.size() > 0) begin
               m_cur = m_q.pop_front();
               m_issued++;
               m_left = GAP - 1;
            end
         2: begin m_drain--; if (m_drain == 0) m_mode = 3; end
         3: if (core_done) m_mode = 4;
         4: begin m_q.delete(); m_mode = 0; end
         default: m_mode = 0;
      endcase
      if (acc) m_q.push_back(in_symbol);
      m_live = 1'b1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_q.delete(); m_cur = 2'b00; m_issued = 0;
      m_len = 0; m_left = 0; m_drain = 0; m_live = 1'b0;
   endtask

   task automatic compare_and_monitor();
      logic e_rdy;
      e_rdy = e_ready();
      total++;
      if (in_ready !== e_rdy || core_BC_mode !== (m_mode == 1) || core_symbol !== m_cur ||
          busy !== (m_mode != 0) || done !== (m_mode == 4) || symbols_issued !== 16'(m_issued)) begin
         bad++;
         $display("FAIL cycle_%0d outputs: got rdy=%b bc=%b sym=%0d busy=%b done=%b iss=%0d, want rdy=%b bc=%b sym=%0d busy=%b done=%b iss=%0d",
                  cyc, in_ready, core_BC_mode, core_symbol, busy, done, symbols_issued,
                  e_rdy, (m_mode == 1), m_cur, (m_mode != 0), (m_mode == 4), m_issued);
      end
      if (!RST) begin
         if (symbols_issued == prev_iss + 16'd1) begin
            issue_log.push_back(core_symbol);
            issue_cyc.push_back(cyc);
         end
         if (prev_bc && !core_BC_mode) bc_fall_cyc = cyc;
         if (core_BC_mode) bc_high++;
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
      prev_iss = symbols_issued;
      prev_bc  = core_BC_mode;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic send(input logic [1:0] s);
      bit ok;
      ok = 1'b0;
      in_valid  = 1'b1;
      in_symbol = s;
      for (int n = 0; n < 400 && !ok; n++) begin
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (ok) exp_syms.push_back(s);
      else check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_start(input int len);
      start   = 1'b1;
      seq_len = 16'(len);
      tick();
      start   = 1'b0;
   endtask

   task automatic finish_seq(input string tag, input int budget);
      int base;
      base = done_cnt;
      core_done = 1'b1;
      for (int n = 0; n < budget && done_cnt == base; n++) tick();
      core_done = 1'b0;
      repeat (3) tick();
      check({tag, "_done_pulses"}, done_cnt - base, 32'd1);
   endtask

   task automatic check_log(input string tag, input int base);
      check({tag, "_issue_count"}, issue_log.size() - base, exp_syms.size());
      for (int i = 0; i < exp_syms.size(); i++) begin
         if (base + i < issue_log.size())
            check($sformatf("%s_sym%0d", tag, i), issue_log[base + i], exp_syms[i]);
      end
   endtask

   task automatic run_tests();
      int base, dbase, bbase, scyc;
      logic [1:0] p1 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      logic [1:0] p2 [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
      logic [1:0] p5 [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      logic [1:0] p6 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

      repeat (3) tick();
      check("rst_ready", in_ready, 32'd0);
      check("rst_busy", busy, 32'd0);
      RST = 1'b0;
      tick();
      check("ready_after_release", in_ready, 32'd1);

      // prefilled full sequence of 8
      exp_syms.delete();
      base = issue_log.size();
      foreach (p1[i]) send(p1[i]);
      check("t1_ready_when_full", in_ready, 32'd0);
      do_start(8);
      finish_seq("t1", 300);
      check_log("t1", base);
      if (issue_log.size() > base) check("t1_bc_fall_after_issue", bc_fall_cyc - issue_cyc[base], 32'd16);
      check("t1_issued", symbols_issued, 32'd8);

      // upstream gapped by 5 idle cycles
      exp_syms.delete();
      base = issue_log.size();
      do_start(4);
      foreach (p2[i]) begin send(p2[i]); repeat (5) tick(); end
      finish_seq("t2", 300);
      check_log("t2", base);
      if (issue_log.size() > base + 1) check("t2_issue_spacing", issue_cyc[base + 1] - issue_cyc[base], 32'd6);
      check("t2_issued", symbols_issued, 32'd4);

      // zero-length sequence, early core_done ignored
      dbase = done_cnt;
      bbase = bc_high;
      do_start(0);
      scyc = cyc;
      repeat (10) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      repeat (20) tick();
      check("t3_no_early_done", done_cnt - dbase, 32'd0);
      finish_seq("t3", 200);
      check("t3_done_latency", done_cyc - scyc, 32'd65);
      check("t3_bc_never_high", bc_high - bbase, 32'd0);

      // core_done stuck high from before start
      exp_syms.delete();
      base = issue_log.size();
      core_done = 1'b1;
      send(2'd2);
      send(2'd1);
      do_start(2);
      finish_seq("t4", 300);
      check_log("t4", base);
      if (issue_log.size() > base) check("t4_done_after_drain", done_cyc - issue_cyc[base], 32'd69);

      // reset mid-run after three issues
      exp_syms.delete();
      dbase = done_cnt;
      foreach (p5[i]) send(p5[i]);
      do_start(8);
      for (int n = 0; n < 100 && symbols_issued != 16'd3; n++) tick();
      check("t5_reached_three", symbols_issued, 32'd3);
      RST = 1'b1;
      tick();
      tick();
      check("t5_rst_bc", core_BC_mode, 32'd0);
      check("t5_rst_sym", core_symbol, 32'd0);
      check("t5_rst_issued", symbols_issued, 32'd0);
      check("t5_rst_ready", in_ready, 32'd0);
      RST = 1'b0;
      tick();
      check("t5_ready_after_release", in_ready, 32'd1);
      check("t5_no_done_on_abort", done_cnt - dbase, 32'd0);
      exp_syms.delete();
      base = issue_log.size();
      send(2'd1);
      send(2'd3);
      do_start(2);
      finish_seq("t5b", 300);
      check_log("t5b", base);
      check("t5b_issued", symbols_issued, 32'd2);

      // full FIFO with a pop due: no push that cycle, nothing overwritten
      exp_syms.delete();
      base = issue_log.size();
      foreach (p6[i]) send(p6[i]);
      do_start(10);
      check("t6_ready_full_with_pop", in_ready, 32'd0);
      send(2'd1);
      send(2'd2);
      finish_seq("t6", 400);
      check_log("t6", base);
      check("t6_issued", symbols_issued, 32'd10);
   endtask

   initial begin
      fork
         forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else model_step();
         end
         forever begin
            @(negedge CLK);
            cyc++;
            compare_and_monitor();
         end
         run_tests();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/symbol_scheduler.md
SYMBOL_SCHEDULER -- requirements
Module: symbol_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the symbol buffer depth (power of 2, at least 2).
REQ-002 The block SHALL have parameter ISSUE_GAP, default 2, meaning cycles each symbol is held on core_symbol (at least 1).
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 64, meaning cycles BC_mode is held low after the last symbol.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begin a sequence, single-cycle pulse.
REQ-007 The block SHALL have port seq_len, input, 16 bits: number of symbols to issue, sampled when start is accepted.
REQ-008 The block SHALL have ports in_symbol (input, 2 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): upstream symbol stream.
REQ-009 The block SHALL have port core_symbol, output, 2 bits: symbol driven to the matching core.
REQ-010 The block SHALL have port core_BC_mode, output, 1 bit: matching-mode enable to the core.
REQ-011 The block SHALL have port core_done, input, 1 bit: completion flag from the core.
REQ-012 The block SHALL have ports busy (output, 1 bit), done (output, 1 bit) and symbols_issued (output, 16 bits): status.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN, WAIT_CORE and FINISH.
REQ-014 In IDLE, start SHALL latch seq_len, clear symbols_issued and move to RUN, or to DRAIN when seq_len is 0; start SHALL be ignored in all other states.
REQ-015 A transfer SHALL occur when in_valid and in_ready are both high on a CLK edge; in_ready SHALL equal (FIFO not full) in IDLE and RUN and SHALL be 0 otherwise.
REQ-016 in_ready SHALL derive from registered occupancy only; on full, a same-cycle pop SHALL NOT enable a push.
REQ-017 In RUN, core_BC_mode SHALL be 1; the block SHALL pop one symbol onto core_symbol, hold it for ISSUE_GAP cycles, then pop the next symbol.
REQ-018 On each pop, symbols_issued SHALL increment by 1; it SHALL saturate at seq_len.
REQ-019 If the FIFO is empty when a pop is due, core_symbol SHALL hold its value, the gap counter SHALL freeze, and issue SHALL resume on the first cycle the FIFO is non-empty.
REQ-020 After the hold period of symbol number seq_len completes, the FSM SHALL enter DRAIN.
REQ-021 In DRAIN, core_BC_mode SHALL be 0 and core_symbol SHALL be 2'b00 for exactly DRAIN_CYCLES cycles; the FSM SHALL then enter WAIT_CORE.
REQ-022 WAIT_CORE SHALL remain until core_done is 1, then go to FINISH; core_done at any other time SHALL be ignored.
REQ-023 In FINISH, done SHALL be 1 for exactly one cycle, the FIFO SHALL be flushed, and the FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 While RST is 1, the state SHALL be IDLE, the FIFO SHALL be empty, and core_symbol=0, core_BC_mode=0, done=0, busy=0, symbols_issued=0, in_ready=0.
REQ-026 Asserting RST mid-sequence SHALL abort it immediately with no done pulse; the FIFO contents SHALL be discarded.
REQ-027 On the first edge after RST deasserts, in_ready SHALL be 1.

Structure
REQ-028 Package mfa_pkg SHALL hold the state enum, a 2-bit symbol typedef and default parameter constants.
REQ-029 The FIFO SHALL be sub-module sym_fifo (push, pop, full, empty, flush), and the gap and drain counters SHALL reside in symbol_scheduler.

Verification
REQ-030 Prefill 8 symbols, start with seq_len=8 -> each symbol held 2 cycles with core_BC_mode=1; BC_mode falls 16 cycles after the first issue; symbols_issued=8.
REQ-031 With seq_len=4 and in_valid gapped by 5 cycles -> core_symbol holds through the stall, the count stays correct, and no symbol is lost or duplicated.
REQ-032 With seq_len=0 -> immediate DRAIN; core_BC_mode stays 0; done is asserted once core_done is asserted after 64 drain cycles.
REQ-033 With core_done held at 1 from the start -> done is asserted only after RUN and DRAIN complete, as a single-cycle pulse.
REQ-034 RST pulsed during RUN with symbols_issued=3 -> all outputs return to reset values, there is no done pulse, and a new start runs cleanly.
REQ-035 FIFO full with a simultaneous pop -> in_ready=0 in that cycle; upstream data is never overwritten.
